// File: rtl/chain_score_reduce.sv
// Chaining DP reduction: folds per-predecessor scores into f(i) and the best
// predecessor p(i), emits them over valid/ready, and tracks the global best chain end.
module chain_score_reduce #(
    parameter int SCORE_W = 32,
    parameter int IDX_W   = 16,
    parameter int CNT_W   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [IDX_W-1:0]   anchor_idx,
    input  logic [SCORE_W-1:0] w_i,
    input  logic [CNT_W-1:0]   num_pred,
    input  logic               in_valid,
    input  logic [SCORE_W-1:0] in_score,
    input  logic [IDX_W-1:0]   in_pred_idx,
    input  logic [SCORE_W-1:0] in_pred_f,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SCORE_W-1:0] out_f,
    output logic [IDX_W-1:0]   out_p,
    output logic [IDX_W-1:0]   out_idx,
    output logic               busy,
    input  logic               gbest_clear,
    output logic [SCORE_W-1:0] gbest_f,
    output logic [IDX_W-1:0]   gbest_idx,
    output logic               protocol_err
);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    localparam logic [SCORE_W-1:0] SENTINEL = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic [SCORE_W-1:0] MAX_POS  = {1'b0, {(SCORE_W-1){1'b1}}};
    localparam logic [SCORE_W-1:0] MIN_OK   = {1'b1, {(SCORE_W-2){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]   NO_PRED  = {IDX_W{1'b1}};

    state_t                    state;
    logic [CNT_W-1:0]          remaining;
    logic [IDX_W-1:0]          idx_q;
    logic signed [SCORE_W-1:0] best;
    logic [IDX_W-1:0]          bestp;

    logic [SCORE_W:0]          sum;
    logic signed [SCORE_W-1:0] cand;
    logic signed [SCORE_W-1:0] best_nxt;
    logic [IDX_W-1:0]          bestp_nxt;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sum       = {in_pred_f[SCORE_W-1], in_pred_f} + {in_score[SCORE_W-1], in_score};
        cand      = sum[SCORE_W-1:0];
        best_nxt  = best;
        bestp_nxt = bestp;
        // Saturate on overflow and keep the rejected-pair sentinel out of the result space.
        if (sum[SCORE_W] != sum[SCORE_W-1]) begin
            cand = sum[SCORE_W] ? MIN_OK : MAX_POS;
        end else if (sum[SCORE_W-1:0] == SENTINEL) begin
            cand = MIN_OK;
        end
        if (in_score != SENTINEL && cand > best) begin
            best_nxt  = cand;
            bestp_nxt = in_pred_idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            remaining    <= '0;
            idx_q        <= '0;
            best         <= '0;
            bestp        <= '0;
            out_valid    <= 1'b0;
            out_f        <= '0;
            out_p        <= NO_PRED;
            out_idx      <= '0;
            busy         <= 1'b0;
            gbest_f      <= SENTINEL;
            gbest_idx    <= '0;
            protocol_err <= 1'b0;
        end else begin
            if ((start && state != IDLE) || (in_valid && state != ACCUM)) begin
                protocol_err <= 1'b1;
            end

            // A clear in the handshake cycle wins; that result is not recorded.
            if (gbest_clear) begin
                gbest_f   <= SENTINEL;
                gbest_idx <= '0;
            end else if (out_valid && out_ready && $signed(out_f) > $signed(gbest_f)) begin
                gbest_f   <= out_f;
                gbest_idx <= out_idx;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        idx_q <= anchor_idx;
                        best  <= $signed(w_i);
                        bestp <= NO_PRED;
                        busy  <= 1'b1;
                        if (num_pred == '0) begin
                            state     <= EMIT;
                            out_valid <= 1'b1;
                            out_f     <= w_i;
                            out_p     <= NO_PRED;
                            out_idx   <= anchor_idx;
                        end else begin
                            state     <= ACCUM;
                            remaining <= num_pred;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        remaining <= remaining - CNT_W'(1);
                        best      <= best_nxt;
                        bestp     <= bestp_nxt;
                        if (remaining == CNT_W'(1)) begin
                            state     <= EMIT;
                            out_valid <= 1'b1;
                            out_f     <= best_nxt;
                            out_p     <= bestp_nxt;
                            out_idx   <= idx_q;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chain_score_reduce.sv
// Randomized self-checking bench for chain_score_reduce against a 64-bit arithmetic
// model of the chaining recurrence and of the global-best tracker.
module tb_chain_score_reduce;

    localparam int SENT = 32'h80000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] anchor_idx;
    logic [31:0] w_i;
    logic [6:0]  num_pred;
    logic        in_valid;
    logic [31:0] in_score;
    logic [15:0] in_pred_idx;
    logic [31:0] in_pred_f;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_f;
    logic [15:0] out_p;
    logic [15:0] out_idx;
    logic        busy;
    logic        gbest_clear;
    logic [31:0] gbest_f;
    logic [15:0] gbest_idx;
    logic        protocol_err;

    chain_score_reduce dut (
        .clk(clk), .reset(reset), .start(start), .anchor_idx(anchor_idx), .w_i(w_i),
        .num_pred(num_pred), .in_valid(in_valid), .in_score(in_score),
        .in_pred_idx(in_pred_idx), .in_pred_f(in_pred_f), .out_valid(out_valid),
        .out_ready(out_ready), .out_f(out_f), .out_p(out_p), .out_idx(out_idx),
        .busy(busy), .gbest_clear(gbest_clear), .gbest_f(gbest_f),
        .gbest_idx(gbest_idx), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] bj [0:127];
    int          bf [0:127];
    int          bs [0:127];

    int          gb_f   = SENT;
    logic [15:0] gb_idx = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // f(i) = max(w, max over accepted j of sat(f(j)+s)); strict compare keeps earliest tie.
    function automatic void model(input int w, input int n, output int f, output logic [15:0] p);
        longint best = w;
        longint c;
        p = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            if (bs[k] == SENT) continue;
            c = longint'(bf[k]) + longint'(bs[k]);
            if (c > 64'sd2147483647) c = 64'sd2147483647;
            if (c < -64'sd2147483647) c = -64'sd2147483647;
            if (c > best) begin
                best = c;
                p    = bj[k];
            end
        end
        f = int'(best);
    endfunction

    task automatic run_anchor(input logic [15:0] idx, input int w, input int n,
                              input int max_gap, input int rdy_wait,
                              input bit inject, input bit clr_hs);
        int          ef;
        logic [15:0] ep;
        model(w, n, ef, ep);
        start = 1'b1; anchor_idx = idx; w_i = w; num_pred = 7'(n);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int k = 0; k < n; k++) begin
            if (inject && k == 1) begin
                start = 1'b1; anchor_idx = idx ^ 16'h00FF; w_i = 32'h7FFFFFFF; num_pred = 7'd0;
                @(negedge clk);
                start = 1'b0;
            end
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            in_valid = 1'b1; in_pred_idx = bj[k]; in_pred_f = bf[k]; in_score = bs[k];
            @(negedge clk);
            in_valid = 1'b0;
        end
        check("out_valid_latency", {31'd0, out_valid}, 32'd1);
        check("out_f", out_f, ef);
        check("out_p", {16'd0, out_p}, {16'd0, ep});
        check("out_idx", {16'd0, out_idx}, {16'd0, idx});
        check("gbest_f_pre", gbest_f, gb_f);
        if (rdy_wait > 0) begin
            repeat (rdy_wait) @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_f", out_f, ef);
            check("hold_p", {16'd0, out_p}, {16'd0, ep});
        end
        out_ready = 1'b1; gbest_clear = clr_hs;
        if (inject) begin
            start = 1'b1; anchor_idx = idx ^ 16'h0F0F; w_i = 32'd1; num_pred = 7'd0;
        end
        @(negedge clk);
        out_ready = 1'b0; gbest_clear = 1'b0; start = 1'b0;
        if (clr_hs) begin
            gb_f = SENT; gb_idx = '0;
        end else if (ef > gb_f) begin
            gb_f = ef; gb_idx = idx;
        end
        check("idle_valid", {31'd0, out_valid}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("gbest_f", gbest_f, gb_f);
        check("gbest_idx", {16'd0, gbest_idx}, {16'd0, gb_idx});
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; anchor_idx = '0; w_i = '0; num_pred = '0;
        in_valid = 1'b0; in_score = '0; in_pred_idx = '0; in_pred_f = '0;
        out_ready = 1'b0; gbest_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_f", out_f, 32'd0);
        check("rst_p", {16'd0, out_p}, 32'h0000FFFF);
        check("rst_idx", {16'd0, out_idx}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_gbest_f", gbest_f, 32'h80000000);
        check("rst_gbest_idx", {16'd0, gbest_idx}, 32'd0);
        check("rst_perr", {31'd0, protocol_err}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Empty predecessor list.
        run_anchor(16'd5, 15, 0, 0, 0, 1'b0, 1'b0);

        // Tie between first and third candidates keeps the first.
        bj[0] = 16'd8; bf[0] = 20; bs[0] = -4;
        bj[1] = 16'd7; bf[1] = 30; bs[1] = -20;
        bj[2] = 16'd6; bf[2] = 25; bs[2] = -9;
        run_anchor(16'd9, 10, 3, 0, 0, 1'b0, 1'b0);

        // All pairs rejected.
        bj[0] = 16'd3; bf[0] = 100; bs[0] = SENT;
        bj[1] = 16'd2; bf[1] = 200; bs[1] = SENT;
        run_anchor(16'd11, 7, 2, 1, 0, 1'b0, 1'b0);

        // Positive saturation with backpressure.
        bj[0] = 16'd4; bf[0] = 32'h7FFFFFF0; bs[0] = 32'h100;
        run_anchor(16'd12, 0, 1, 0, 5, 1'b0, 1'b0);

        // Negative saturation must not yield the sentinel.
        bj[0] = 16'd1; bf[0] = 32'h80000010; bs[0] = -32'sd1000;
        run_anchor(16'd13, SENT, 1, 0, 0, 1'b0, 1'b0);

        // Protocol violations: in_valid in IDLE, start in ACCUM and in the EMIT handshake.
        in_valid = 1'b1; in_score = 32'd5; in_pred_f = 32'd5000; in_pred_idx = 16'd77;
        @(negedge clk);
        in_valid = 1'b0;
        check("perr_idle_valid", {31'd0, protocol_err}, 32'd1);
        bj[0] = 16'd30; bf[0] = 50; bs[0] = 1;
        bj[1] = 16'd31; bf[1] = 60; bs[1] = 2;
        bj[2] = 16'd32; bf[2] = 40; bs[2] = 3;
        run_anchor(16'd40, 0, 3, 2, 2, 1'b1, 1'b0);
        check("perr_sticky", {31'd0, protocol_err}, 32'd1);

        // Reset mid-ACCUM discards the partial reduction.
        start = 1'b1; anchor_idx = 16'd20; w_i = 32'd500; num_pred = 7'd3;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_pred_idx = 16'd19; in_pred_f = 32'd900; in_score = 32'd9;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_perr", {31'd0, protocol_err}, 32'd0);
        check("mid_rst_gbest", gbest_f, 32'h80000000);
        @(negedge clk);
        reset = 1'b1;
        gb_f = SENT; gb_idx = '0;
        @(negedge clk);
        bj[0] = 16'd21; bf[0] = 3; bs[0] = 4;
        run_anchor(16'd22, 1, 1, 0, 0, 1'b0, 1'b0);

        // Clear coinciding with a handshake wins over the update.
        bj[0] = 16'd23; bf[0] = 1000; bs[0] = 1;
        run_anchor(16'd24, 0, 1, 0, 0, 1'b0, 1'b1);

        // Randomized anchors with small value ranges so ties are frequent.
        for (int a = 0; a < 40; a++) begin
            int n;
            n = $urandom_range(0, 8);
            for (int k = 0; k < n; k++) begin
                int r;
                r = $urandom_range(0, 9);
                bj[k] = 16'($urandom);
                if (r == 0) begin
                    bf[k] = int'($urandom_range(0, 40)); bs[k] = SENT;
                end else if (r == 1) begin
                    bf[k] = int'($urandom); bs[k] = int'($urandom);
                end else begin
                    bf[k] = int'($urandom_range(0, 40));
                    bs[k] = int'($urandom_range(0, 40)) - 20;
                end
            end
            run_anchor(16'($urandom), int'($urandom_range(0, 40)) - 10, n,
                       $urandom_range(0, 2), $urandom_range(0, 3), 1'b0,
                       ($urandom_range(0, 9) == 0));
        end
        check("perr_final", {31'd0, protocol_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
